// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side drives hazard inputs; the controller returns stall/flush.
interface hazard_if;
    logic       BranchD;
    logic       JrD;
    logic       PCSrcD;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] WriteRegE;
    logic       MemtoRegM;
    logic [4:0] WriteRegM;
    logic       ICacheStall;
    logic       DCacheStall;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       StallW;
    logic       FlushD;
    logic       FlushE;
    logic       MemWait;
    logic       Timeout;

    modport master (
        output BranchD, JrD, PCSrcD, RsD, RtD, RsE, RtE,
        output RegWriteE, MemtoRegE, WriteRegE,
        output MemtoRegM, WriteRegM, ICacheStall, DCacheStall,
        input  StallF, StallD, StallE, StallM, StallW,
        input  FlushD, FlushE, MemWait, Timeout
    );

    modport slave (
        input  BranchD, JrD, PCSrcD, RsD, RtD, RsE, RtE,
        input  RegWriteE, MemtoRegE, WriteRegE,
        input  MemtoRegM, WriteRegM, ICacheStall, DCacheStall,
        output StallF, StallD, StallE, StallM, StallW,
        output FlushD, FlushE, MemWait, Timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core, with cache-miss freeze.
// Optional HAZARD_PERF_EN adds stall and flush performance counters.
module hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef HAZARD_PERF_EN
    output logic [31:0] PerfStallCnt,
    output logic [31:0] PerfFlushCnt,
`endif
    hazard_if.slave     bus
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_q;

    logic rs_e, rt_e, rs_m, rt_m;
    logic lduse, brhaz, hz, mstall;

    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_d, flush_e, mem_wait;

    // Execute-stage sources belong to the forwarding unit, not to us.
    wire unused_e = ^{bus.RsE, bus.RtE};

    assign rs_e = (bus.WriteRegE != 5'd0) && (bus.WriteRegE == bus.RsD);
    assign rt_e = (bus.WriteRegE != 5'd0) && (bus.WriteRegE == bus.RtD);
    assign rs_m = (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RsD);
    assign rt_m = (bus.WriteRegM != 5'd0) && (bus.WriteRegM == bus.RtD);

    assign lduse = bus.MemtoRegE & (rs_e | rt_e);

    // jr only reads rs; branches compare both operands.
    assign brhaz =
        (bus.BranchD & ((bus.RegWriteE & (rs_e | rt_e)) |
                        (bus.MemtoRegM & (rs_m | rt_m)))) |
        (bus.JrD     & ((bus.RegWriteE & rs_e) |
                        (bus.MemtoRegM & rs_m)));

    assign hz     = lduse | brhaz;
    assign mstall = bus.ICacheStall | bus.DCacheStall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RUN;
        else        state <= next_state;
    end

    // Miss-duration counter; saturates so the timeout compare fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && mstall) begin
            if (wait_cnt != CNT_W'(MAX_WAIT))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky timeout, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_q <= 1'b0;
        else if (state == S_WAIT && mstall &&
                 wait_cnt == CNT_W'(MAX_WAIT - 1))
            timeout_q <= 1'b1;
    end

    // Next state and stall/flush decode; freeze dominates hazards.
    always_comb begin
        next_state = state;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        stall_w    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        mem_wait   = 1'b0;
        unique case (state)
            S_RUN: begin
                if (mstall) begin
                    next_state = S_WAIT;
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    stall_m    = 1'b1;
                    stall_w    = 1'b1;
                end else begin
                    stall_f = hz;
                    stall_d = hz;
                    flush_e = hz;
                    flush_d = bus.PCSrcD & ~hz;
                end
            end
            S_WAIT: begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                stall_m  = 1'b1;
                stall_w  = 1'b1;
                mem_wait = 1'b1;
                if (!mstall) next_state = S_RUN;
            end
            default: next_state = S_RUN;
        endcase
    end

    // Outputs are held low for as long as reset is asserted.
    assign bus.StallF  = stall_f   & rst_n;
    assign bus.StallD  = stall_d   & rst_n;
    assign bus.StallE  = stall_e   & rst_n;
    assign bus.StallM  = stall_m   & rst_n;
    assign bus.StallW  = stall_w   & rst_n;
    assign bus.FlushD  = flush_d   & rst_n;
    assign bus.FlushE  = flush_e   & rst_n;
    assign bus.MemWait = mem_wait  & rst_n;
    assign bus.Timeout = timeout_q & rst_n;

`ifdef HAZARD_PERF_EN
    // Stall and flush event counters, wrapping mod 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PerfStallCnt <= 32'd0;
            PerfFlushCnt <= 32'd0;
        end else begin
            if (stall_f)
                PerfStallCnt <= PerfStallCnt + 32'd1;
            if (flush_d | flush_e)
                PerfFlushCnt <= PerfFlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl against a behavioural model.
// Define HAZARD_PERF_EN to also check the performance counters.
module tb_hazard_ctrl;

    localparam int MW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic       rst_n;
        logic       br;
        logic       jr;
        logic       pcsrc;
        logic [4:0] rsd;
        logic [4:0] rtd;
        logic [4:0] rse;
        logic [4:0] rte;
        logic       rwe;
        logic       m2re;
        logic [4:0] wre;
        logic       m2rm;
        logic [4:0] wrm;
        logic       ic;
        logic       dc;
    } in_t;

    // o = {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,MemWait,Timeout}
    typedef struct packed {
        logic [8:0]  o;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    hazard_if bus();

    hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef HAZARD_PERF_EN
        .PerfStallCnt (perf_stall),
        .PerfFlushCnt (perf_flush),
`endif
        .bus          (bus)
    );

`ifndef HAZARD_PERF_EN
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
`endif

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: previous-cycle miss, run length of the miss, sticky flag.
    logic        m_prev_ms;
    int          m_run;
    logic        m_to;
    logic [31:0] m_ps;
    logic [31:0] m_pf;
    in_t         last;
    exp_t        last_exp;

    string names [9] = '{"StallF", "StallD", "StallE", "StallM", "StallW",
                         "FlushD", "FlushE", "MemWait", "Timeout"};

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.rst_n = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_prev_ms = 1'b0;
        m_run     = 0;
        m_to      = 1'b0;
        m_ps      = 32'd0;
        m_pf      = 32'd0;
    endtask

    // Advance model across one clock edge using the inputs of the cycle just ended.
    task automatic model_edge();
        logic ms;
        if (!last.rst_n) begin
            model_reset();
        end else begin
            ms = last.ic | last.dc;
            if (ms) begin
                m_run = m_run + 1;
                if (m_run == MW + 1) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            m_prev_ms = ms;
            if (last_exp.o[8]) m_ps = m_ps + 32'd1;
            if (last_exp.o[3] | last_exp.o[2]) m_pf = m_pf + 32'd1;
        end
    endtask

    function automatic exp_t model_out(input in_t v);
        exp_t e;
        logic ms, frz, lduse, brh, hzd, e_rs, e_rt, m_rs, m_rt;
        e = '0;
        if (!v.rst_n) return e;
        e_rs = v.wre != 0 && v.wre == v.rsd;
        e_rt = v.wre != 0 && v.wre == v.rtd;
        m_rs = v.wrm != 0 && v.wrm == v.rsd;
        m_rt = v.wrm != 0 && v.wrm == v.rtd;
        lduse = v.m2re && (e_rs || e_rt);
        brh = 1'b0;
        if (v.br && ((v.rwe && (e_rs || e_rt)) || (v.m2rm && (m_rs || m_rt))))
            brh = 1'b1;
        if (v.jr && ((v.rwe && e_rs) || (v.m2rm && m_rs)))
            brh = 1'b1;
        hzd = lduse || brh;
        ms  = v.ic | v.dc;
        frz = ms | m_prev_ms;
        if (frz)
            e.o = {5'b11111, 2'b00, m_prev_ms, m_to};
        else
            e.o = {hzd, hzd, 3'b000, v.pcsrc & ~hzd, hzd, 1'b0, m_to};
        e.ps = m_ps;
        e.pf = m_pf;
        return e;
    endfunction

    task automatic apply(input in_t v);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        if (!v.rst_n) model_reset();
        rst_n           = v.rst_n;
        bus.BranchD     = v.br;
        bus.JrD         = v.jr;
        bus.PCSrcD      = v.pcsrc;
        bus.RsD         = v.rsd;
        bus.RtD         = v.rtd;
        bus.RsE         = v.rse;
        bus.RtE         = v.rte;
        bus.RegWriteE   = v.rwe;
        bus.MemtoRegE   = v.m2re;
        bus.WriteRegE   = v.wre;
        bus.MemtoRegM   = v.m2rm;
        bus.WriteRegM   = v.wrm;
        bus.ICacheStall = v.ic;
        bus.DCacheStall = v.dc;
        e = model_out(v);
        q.push_back(e);
        last     = v;
        last_exp = e;
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        logic bad;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                   bus.StallW, bus.FlushD, bus.FlushE, bus.MemWait,
                   bus.Timeout};
            bad = 1'b0;
            vectors++;
            for (int i = 0; i < 9; i++) begin
                if (act[8-i] !== e.o[8-i]) begin
                    $display("FAIL %s @%0t: got %b want %b",
                             names[i], $time, act[8-i], e.o[8-i]);
                    bad = 1'b1;
                end
            end
`ifdef HAZARD_PERF_EN
            if (perf_stall !== e.ps) begin
                $display("FAIL PerfStallCnt @%0t: got %0d want %0d",
                         $time, perf_stall, e.ps);
                bad = 1'b1;
            end
            if (perf_flush !== e.pf) begin
                $display("FAIL PerfFlushCnt @%0t: got %0d want %0d",
                         $time, perf_flush, e.pf);
                bad = 1'b1;
            end
`endif
            if (bad) miscompares++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;
        int  burst;
        int  rst_hold;
        logic bdc;

        last     = '0;
        last_exp = '0;
        model_reset();
        rst_n = 1'b0;
        bus.BranchD = 0; bus.JrD = 0; bus.PCSrcD = 0;
        bus.RsD = 0; bus.RtD = 0; bus.RsE = 0; bus.RtE = 0;
        bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.WriteRegE = 0;
        bus.MemtoRegM = 0; bus.WriteRegM = 0;
        bus.ICacheStall = 0; bus.DCacheStall = 0;

        // Reset state, with hazard inputs active to show they are masked.
        v = idle(); v.rst_n = 0; v.m2re = 1; v.wre = 5; v.rsd = 5; v.dc = 1;
        apply(v);
        apply(v);
        apply(idle());

        // 1: load-use.
        v = idle(); v.m2re = 1; v.wre = 5; v.rsd = 5;
        apply(v);
        apply(idle());

        // 2: branch on ALU result in Execute, then taken.
        v = idle(); v.br = 1; v.rsd = 3; v.rwe = 1; v.wre = 3;
        apply(v);
        v = idle(); v.br = 1; v.rsd = 3; v.wrm = 3; v.pcsrc = 1;
        apply(v);
        // jr on a load in Memory; rt must be ignored for jr.
        v = idle(); v.jr = 1; v.rsd = 7; v.m2rm = 1; v.wrm = 7;
        apply(v);
        v = idle(); v.jr = 1; v.rsd = 1; v.rtd = 7; v.m2rm = 1; v.wrm = 7;
        apply(v);
        // $0 never matches.
        v = idle(); v.m2re = 1; v.wre = 0; v.rsd = 0; v.pcsrc = 1;
        apply(v);

        // 3: five-cycle D-cache miss.
        v = idle(); v.dc = 1;
        repeat (5) apply(v);
        repeat (2) apply(idle());

        // 4: I-cache miss longer than MAX_WAIT.
        v = idle(); v.ic = 1;
        repeat (MW + 3) apply(v);
        repeat (3) apply(idle());

        // 5: load-use + taken branch + miss together.
        v = idle(); v.m2re = 1; v.wre = 5; v.rsd = 5; v.pcsrc = 1; v.dc = 1;
        repeat (2) apply(v);
        v.dc = 0;
        apply(v);
        apply(v);
        v = idle(); v.pcsrc = 1;
        apply(v);

        // 6: reset in the middle of a miss.
        v = idle(); v.dc = 1;
        repeat (MW + 4) apply(v);
        v.rst_n = 0;
        repeat (2) apply(v);
        apply(idle());
        apply(idle());

        // Random traffic with bursty cache misses and rare resets.
        burst = 0;
        rst_hold = 0;
        bdc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            v       = idle();
            v.br    = 1'($urandom_range(0, 1));
            v.jr    = ($urandom_range(0, 5) == 0);
            v.pcsrc = 1'($urandom_range(0, 1));
            v.rsd   = 5'($urandom_range(0, 3));
            v.rtd   = 5'($urandom_range(0, 3));
            v.rse   = 5'($urandom_range(0, 31));
            v.rte   = 5'($urandom_range(0, 31));
            v.rwe   = 1'($urandom_range(0, 1));
            v.m2re  = ($urandom_range(0, 2) == 0);
            v.wre   = 5'($urandom_range(0, 3));
            v.m2rm  = ($urandom_range(0, 2) == 0);
            v.wrm   = 5'($urandom_range(0, 3));
            if (burst == 0 && $urandom_range(0, 19) == 0) begin
                burst = $urandom_range(1, MW + 4);
                bdc   = 1'($urandom_range(0, 1));
            end
            if (burst > 0) begin
                if (bdc) v.dc = 1'b1;
                else     v.ic = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    v.ic = 1'b1;
                    v.dc = 1'b1;
                end
                burst--;
            end
            if (rst_hold == 0 && $urandom_range(0, 499) == 0)
                rst_hold = $urandom_range(1, 2);
            if (rst_hold > 0) begin
                v.rst_n = 1'b0;
                rst_hold--;
            end
            apply(v);
        end
        apply(idle());

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
